// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM stage and a variable-latency memory.
// Request side is registered by the master; the slave strobes dmem_ack once per access.
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access.sv
// MEM stage of the MIPS pipeline: issues one bus access per load/store, stalls
// the pipeline until it completes, formats load data and flags misalignment/timeouts.
module mem_access #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         MemRead_EX,
    input  logic         MemWrite_EX,
    input  logic [31:0]  Alu_result_EX,
    input  logic [31:0]  Rt_data_EX,
    input  logic [31:0]  Instruction_EX,
    output logic [31:0]  Mem_read_data,
    output logic         Mem_stall,
    output logic         Addr_error,
    output logic         Bus_error,
    mem_access_if.master bus
);
    localparam int CNT_W = $clog2(BUS_TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d, we_q, we_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]       be_q, be_d;
    logic             aerr_q, aerr_d, berr_q, berr_d;
    logic             ld_q, ld_d, lsgn_q, lsgn_d;
    logic [1:0]       lsz_q, lsz_d, off_q, off_d;

    logic [5:0]  op;
    logic        is_wr, is_rd, access, misal, sgn;
    logic [1:0]  sz;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, sh_data, ld_fmt;
    logic        unused_instr;

    assign op           = Instruction_EX[31:26];
    assign unused_instr = ^Instruction_EX[25:0];
    assign is_wr        = MemWrite_EX;
    assign is_rd        = MemRead_EX & ~MemWrite_EX;
    assign access       = is_wr | is_rd;

    // Unknown opcodes fall back to full-word accesses of the requested direction.
    always_comb begin
        sz  = SZ_W;
        sgn = 1'b0;
        if (is_wr) begin
            case (op)
                6'h28:   sz = SZ_B;
                6'h29:   sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end else begin
            case (op)
                6'h20:   begin sz = SZ_B; sgn = 1'b1; end
                6'h21:   begin sz = SZ_H; sgn = 1'b1; end
                6'h24:   sz = SZ_B;
                6'h25:   sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end
    end

    assign misal = ((sz == SZ_H) && Alu_result_EX[0]) ||
                   ((sz == SZ_W) && (Alu_result_EX[1:0] != 2'b00));

    always_comb begin
        case (sz)
            SZ_B: begin
                st_be    = 4'b0001 << Alu_result_EX[1:0];
                st_wdata = {4{Rt_data_EX[7:0]}};
            end
            SZ_H: begin
                st_be    = Alu_result_EX[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{Rt_data_EX[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = Rt_data_EX;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend.
    assign sh_data = bus.dmem_rdata >> {off_q, 3'b000};
    always_comb begin
        case (lsz_q)
            SZ_B:    ld_fmt = {{24{lsgn_q & sh_data[7]}}, sh_data[7:0]};
            SZ_H:    ld_fmt = {{16{lsgn_q & sh_data[15]}}, sh_data[15:0]};
            default: ld_fmt = sh_data;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        aerr_d  = 1'b0;
        berr_d  = 1'b0;
        ld_d    = ld_q;
        lsz_d   = lsz_q;
        lsgn_d  = lsgn_q;
        off_d   = off_q;
        case (state_q)
            S_IDLE: begin
                if (access && misal) begin
                    aerr_d = 1'b1;
                    if (is_rd) rdata_d = 32'h0;
                end else if (access) begin
                    req_d   = 1'b1;
                    we_d    = is_wr;
                    addr_d  = {Alu_result_EX[31:2], 2'b00};
                    be_d    = is_wr ? st_be : 4'b1111;
                    wdata_d = st_wdata;
                    ld_d    = is_rd;
                    lsz_d   = sz;
                    lsgn_d  = sgn;
                    off_d   = Alu_result_EX[1:0];
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.dmem_ack) begin
                    req_d   = 1'b0;
                    if (ld_q) rdata_d = ld_fmt;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(BUS_TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    if (ld_q) rdata_d = 32'h0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
            ld_q    <= 1'b0;
            lsz_q   <= SZ_W;
            lsgn_q  <= 1'b0;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
            ld_q    <= ld_d;
            lsz_q   <= lsz_d;
            lsgn_q  <= lsgn_d;
            off_q   <= off_d;
        end
    end

    // Stall is masked during reset so the pipeline sees a clean idle stage.
    assign Mem_stall = rst & (((state_q == S_IDLE) & access & ~misal) | (state_q == S_WAIT));

    assign Mem_read_data  = rdata_q;
    assign Addr_error     = aerr_q;
    assign Bus_error      = berr_q;
    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_be    = be_q;
    assign bus.dmem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a scripted memory responder, expected load
// results queued at issue and compared when the stage releases its stall.
module tb_mem_access;
    localparam int TO = 4;

    logic        clk, rst;
    logic        MemRead_EX, MemWrite_EX;
    logic [31:0] Alu_result_EX, Rt_data_EX, Instruction_EX;
    logic [31:0] Mem_read_data;
    logic        Mem_stall, Addr_error, Bus_error;

    mem_access_if bus();

    mem_access #(.BUS_TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .MemRead_EX     (MemRead_EX),
        .MemWrite_EX    (MemWrite_EX),
        .Alu_result_EX  (Alu_result_EX),
        .Rt_data_EX     (Rt_data_EX),
        .Instruction_EX (Instruction_EX),
        .Mem_read_data  (Mem_read_data),
        .Mem_stall      (Mem_stall),
        .Addr_error     (Addr_error),
        .Bus_error      (Bus_error),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] md_model;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (op)
            6'h20:   return {{24{b[7]}}, b};
            6'h24:   return {24'h0, b};
            6'h21:   return {{16{h[15]}}, h};
            6'h25:   return {16'h0, h};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input logic wr, input logic [5:0] op, input logic [1:0] off);
        if (!wr) return 4'hF;
        if (op == 6'h28) return 4'b0001 << off;
        if (op == 6'h29) return off[1] ? 4'b1100 : 4'b0011;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] rt);
        if (op == 6'h28) return {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
        if (op == 6'h29) return {rt[15:0], rt[15:0]};
        return rt;
    endfunction

    task automatic drive_idle();
        MemRead_EX = 1'b0; MemWrite_EX = 1'b0;
        Alu_result_EX = 32'h0; Rt_data_EX = 32'h0; Instruction_EX = 32'h0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":md"},    Mem_read_data,          32'h0);
        chk({tag, ":stall"}, 32'(Mem_stall),         32'h0);
        chk({tag, ":aerr"},  32'(Addr_error),        32'h0);
        chk({tag, ":berr"},  32'(Bus_error),         32'h0);
        chk({tag, ":req"},   32'(bus.dmem_req),      32'h0);
        chk({tag, ":we"},    32'(bus.dmem_we),       32'h0);
        chk({tag, ":addr"},  bus.dmem_addr,          32'h0);
        chk({tag, ":be"},    32'(bus.dmem_be),       32'h0);
        chk({tag, ":wdata"}, bus.dmem_wdata,         32'h0);
    endtask

    // Called right after a negedge with the stage in IDLE; ack_at is the WAIT
    // cycle index carrying the ack, or -1 to withhold it.
    task automatic access(input logic rd, input logic wr, input logic [5:0] op,
                          input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] rdat, input int ack_at, input string tag);
        int          waits = 0;
        bit          done = 0;
        bit          tmo;
        logic [31:0] exp_md;
        tmo = (ack_at < 0) || (ack_at >= TO);
        MemRead_EX = rd; MemWrite_EX = wr; Instruction_EX = {op, 26'h0};
        Alu_result_EX = addr; Rt_data_EX = rt;
        bus.dmem_ack = 1'b0;
        #1;
        chk({tag, ":t0_stall"}, 32'(Mem_stall), 32'd1);
        if (wr)       exp_md = md_model;
        else if (tmo) exp_md = 32'h0;
        else          exp_md = exp_load(op, addr[1:0], rdat);
        md_model = exp_md;
        exp_q.push_back(exp_md);
        while (!done && waits < 64) begin
            @(negedge clk);
            if (!Mem_stall) done = 1;
            else begin
                if (waits == 0) begin
                    chk({tag, ":addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
                    chk({tag, ":we"},   32'(bus.dmem_we), 32'(wr));
                    chk({tag, ":be"},   32'(bus.dmem_be), 32'(exp_be(wr, op, addr[1:0])));
                    if (wr) chk({tag, ":wdata"}, bus.dmem_wdata, exp_wdata(op, rt));
                end
                chk({tag, ":req_hi"}, 32'(bus.dmem_req), 32'd1);
                bus.dmem_ack   = (waits == ack_at);
                bus.dmem_rdata = (waits == ack_at) ? rdat : 32'h5A5A_5A5A;
                waits++;
            end
        end
        bus.dmem_ack = 1'b0;
        chk({tag, ":finished"},  32'(done),  32'd1);
        chk({tag, ":wait_cyc"},  32'(waits), tmo ? 32'(TO) : 32'(ack_at + 1));
        chk({tag, ":req_lo"},    32'(bus.dmem_req), 32'd0);
        chk({tag, ":berr"},      32'(Bus_error),    32'(tmo));
        chk({tag, ":aerr"},      32'(Addr_error),   32'd0);
        chk({tag, ":md"},        Mem_read_data,     exp_q.pop_front());
        @(negedge clk);
        drive_idle();
        #1;
        chk({tag, ":after_stall"}, 32'(Mem_stall), 32'd0);
        chk({tag, ":after_berr"},  32'(Bus_error), 32'd0);
        chk({tag, ":after_md"},    Mem_read_data,  md_model);
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        md_model = 32'h0;
        #1;
        chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_stall", 32'(Mem_stall), 32'd0);
        @(negedge clk);

        access(1'b1, 1'b0, 6'h23, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw");
        access(1'b1, 1'b0, 6'h20, 32'h103, 32'h0, 32'h80FF1234, 2, "lb");
        access(1'b1, 1'b0, 6'h24, 32'h103, 32'h0, 32'h80FF1234, 1, "lbu");
        access(1'b1, 1'b0, 6'h24, 32'h102, 32'h0, 32'h80FF1234, 0, "lbu2");
        access(1'b1, 1'b0, 6'h21, 32'h102, 32'h0, 32'h80017FFF, 0, "lh");
        access(1'b1, 1'b0, 6'h25, 32'h100, 32'h0, 32'h80017FFF, 0, "lhu");
        access(1'b0, 1'b1, 6'h29, 32'h102, 32'h0000ABCD, 32'h0, 0, "sh");
        access(1'b0, 1'b1, 6'h28, 32'h101, 32'h1234565A, 32'h0, 1, "sb");
        access(1'b1, 1'b1, 6'h2B, 32'h104, 32'hCAFEF00D, 32'h0, 0, "sw_both");
        access(1'b1, 1'b0, 6'h00, 32'h108, 32'h0, 32'h13579BDF, 0, "ld_other");

        // Misaligned store: no bus cycle, load data untouched.
        MemWrite_EX = 1'b1; Instruction_EX = {6'h29, 26'h0}; Alu_result_EX = 32'h103;
        #1;
        chk("mis_sh:stall", 32'(Mem_stall), 32'd0);
        @(negedge clk);
        chk("mis_sh:aerr", 32'(Addr_error),   32'd1);
        chk("mis_sh:req",  32'(bus.dmem_req), 32'd0);
        chk("mis_sh:md",   Mem_read_data,     md_model);
        drive_idle();
        @(negedge clk);
        chk("mis_sh:aerr_pulse", 32'(Addr_error), 32'd0);

        // Misaligned load: result forced to zero.
        MemRead_EX = 1'b1; Instruction_EX = {6'h23, 26'h0}; Alu_result_EX = 32'h101;
        #1;
        chk("mis_lw:stall", 32'(Mem_stall), 32'd0);
        @(negedge clk);
        md_model = 32'h0;
        chk("mis_lw:aerr",  32'(Addr_error),   32'd1);
        chk("mis_lw:req",   32'(bus.dmem_req), 32'd0);
        chk("mis_lw:stall2", 32'(Mem_stall),   32'd0);
        chk("mis_lw:md",    Mem_read_data,     md_model);
        drive_idle();
        @(negedge clk);
        chk("mis_lw:aerr_pulse", 32'(Addr_error), 32'd0);

        access(1'b1, 1'b0, 6'h23, 32'h004, 32'h0, 32'h0BADF00D, 0, "lw_pre");
        access(1'b1, 1'b0, 6'h23, 32'h010, 32'h0, 32'hDEAD0000, -1, "lw_timeout");
        access(1'b1, 1'b0, 6'h23, 32'h014, 32'h0, 32'h01234567, TO - 1, "lw_lastack");

        // Reset while a request is outstanding.
        MemRead_EX = 1'b1; Instruction_EX = {6'h23, 26'h0}; Alu_result_EX = 32'h200;
        @(negedge clk);
        chk("rst_mid:req_before", 32'(bus.dmem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        md_model = 32'h0;
        #1;
        chk("rst_rel:stall", 32'(Mem_stall), 32'd0);
        @(negedge clk);
        access(1'b1, 1'b0, 6'h23, 32'h300, 32'h0, 32'h89ABCDEF, 1, "lw_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access.md
# mem_access

Data-memory access stage for the pipelined MIPS core. It sits directly upstream of the MEM/WB pipeline register, consuming the EX/MEM outputs (address, store data, instruction, control) and producing the formatted load data that MEM/WB captures. It drives a variable-latency data-memory bus with a req/ack handshake, and holds the pipeline with a stall until each access completes. It also flags misaligned accesses and bus timeouts.

## Interface
- BUS_TIMEOUT, 16: cycles in WAIT without dmem_ack before the access is aborted (≥2).
- clk  in  1  pipeline clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- MemRead_EX  in  1  current instruction is a load.
- MemWrite_EX  in  1  current instruction is a store; wins if both are high.
- Alu_result_EX  in  32  effective byte address.
- Rt_data_EX  in  32  store data (unshifted).
- Instruction_EX  in  32  instruction; opcode [31:26] selects size/sign.
- Mem_read_data  out  32  registered, formatted load result.
- Mem_stall  out  1  1 = upstream pipeline registers must hold.
- Addr_error  out  1  one-cycle pulse on a misaligned access.
- Bus_error  out  1  one-cycle pulse on a bus timeout.
- dmem_req  out  1  registered bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address; Alu_result_EX with [1:0] forced to 0.
- dmem_be  out  4  byte enables for writes; 4'b1111 on reads.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_rdata  in  32  read data; valid when dmem_ack=1.
- dmem_ack  in  1  one-cycle completion strobe.

## Operation
- Opcodes: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B.
  - Any other opcode with MemRead_EX is treated as lw.
  - Any other opcode with MemWrite_EX is treated as sw.
- Byte order is little-endian: offset 0 is bits [7:0].
  - sb: data byte replicated to all lanes, be = 1 << addr[1:0].
  - sh: halfword replicated to both halves, be = 4'b0011 or 4'b1100 by addr[1].
  - sw: be = 4'b1111.
- Load formatting: select the byte/half by addr[1:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes dmem_rdata through.
- Alignment rules: halfword needs addr[0]=0; word needs addr[1:0]=0.
- FSM states are IDLE, WAIT, DONE.
  - IDLE, no access (MemRead_EX=MemWrite_EX=0): stay; Mem_stall=0.
  - IDLE, misaligned access: no bus cycle; Addr_error=1 next cycle; stay IDLE.
    - The access completes as a no-op. Mem_read_data is set to 0 for loads and is unchanged for stores.
    - Mem_stall=0.
  - IDLE, aligned access: Mem_stall=1 combinationally.
    - Latch dmem_addr/we/be/wdata; dmem_req=1 from the next cycle.
    - Go to WAIT and clear the timeout counter.
  - WAIT: dmem_req stays 1 and address/data stay stable; Mem_stall=1.
    - On dmem_ack: dmem_req=0 next cycle. A load registers its formatted data into Mem_read_data. Go to DONE.
    - If the counter reaches BUS_TIMEOUT-1 without ack: dmem_req=0, Bus_error=1 next cycle, Mem_read_data=0 if a load. Go to DONE.
    - If ack arrives in the same cycle as timeout, ack wins and there is no Bus_error.
  - DONE: Mem_stall=0 for exactly one cycle so the pipeline advances; go to IDLE.
    - The access seen on that cycle's inputs is the one just completed. It is not restarted.
- Mem_read_data is held between loads. Stores and non-memory instructions never change it.
- dmem_ack outside WAIT is ignored.

## Timing
- Reset (async, rst=0): state=IDLE, counter=0.
  - All outputs are 0: Mem_read_data, Addr_error, Bus_error, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata.
  - Mem_stall=0.
- Reset mid-access drops dmem_req immediately, and the in-flight access is lost.
- Minimum aligned access takes 3 cycles:
  - T0: IDLE, stall=1.
  - T1: req=1, ack=1.
  - T2: DONE, stall=0, Mem_read_data valid.
  - The pipeline advances at the end of T2.
- An ack arriving k cycles after req rises gives k+2 stalled cycles.
- Back-to-back accesses: the next access is first seen in IDLE one cycle after DONE. Throughput is one access per ≥3 cycles.
- The timeout path takes BUS_TIMEOUT+2 cycles from T0 to the advance.
- Misaligned and non-memory instructions add zero stall cycles.

## Test plan
- lw at address 0x100; memory returns 0xDEADBEEF with ack one cycle after req.
  - Expect stall high T0–T1, low at T2, Mem_read_data=0xDEADBEEF at T2.
  - Expect dmem_addr=0x100, be=4'b1111, we=0.
- lb at 0x103 and lbu at 0x103 with rdata 0x80FF1234.
  - Expect Mem_read_data 0xFFFFFF80 and 0x00000080 respectively.
- sh at 0x102 with Rt_data_EX=0x0000ABCD.
  - Expect we=1, be=4'b1100, wdata=0xABCDABCD, dmem_addr=0x100.
  - Expect Mem_read_data unchanged.
- lw at 0x101.
  - Expect no dmem_req, Addr_error pulse for 1 cycle, Mem_stall never high, Mem_read_data=0.
- Load with BUS_TIMEOUT=4 and ack withheld.
  - Expect req high 4 cycles then drops, Bus_error pulse, Mem_read_data=0, stall released next cycle.
  - Repeat with ack on the last cycle: expect data captured and no Bus_error.
- Assert rst=0 in WAIT with req high.
  - Expect req=0 and all outputs 0 immediately.
  - After release, a new lw completes normally.
